// File: rtl/uart_baud_ctrl.sv
// Sequences BAUDGEN rate changes: bus writes are applied when the link is idle on a baudtick,
// and autobaud measures one start bit and picks the nearest rate. Requests made while busy are rejected with cfg_err.
module uart_baud_ctrl #(
    parameter logic [3:0] RESET_BAUD   = 4'd6,
    parameter int         SETTLE_TICKS = 4,
    parameter int         MEAS_W       = 20,
    parameter int         MIN_W        = 64,
    parameter int         ARM_TIMEOUT  = 2**20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cfg_wr,
    input  logic [3:0] cfg_baud,
    input  logic       auto_req,
    input  logic       link_busy,
    input  logic       rxd,
    input  logic       baudtick,
    output logic [3:0] set_baud,
    output logic       cfg_busy,
    output logic       cfg_err,
    output logic       auto_done,
    output logic       auto_fail
);

    localparam int AW = $clog2(ARM_TIMEOUT + 1);
    localparam int TW = $clog2(SETTLE_TICKS + 1);
    localparam logic [MEAS_W-1:0] W_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, PEND, SETTLE, AUTO_ARM, AUTO_MEAS, AUTO_SRCH
    } state_t;

    state_t            state, state_n;
    logic [3:0]        set_baud_n, pend, pend_n;
    logic [AW-1:0]     arm_cnt, arm_n;
    logic [MEAS_W-1:0] w_cnt, w_n;
    logic [TW-1:0]     tick_cnt, tick_n;
    logic [3:0]        k_cnt, k_n, best, best_n;
    logic [MEAS_W-1:0] best_diff, bd_n;
    logic [MEAS_W-1:0] est, cnt_k, diff;
    logic              err_pend, err_pend_n, err_n, done_n, fail_n, reject;
    logic              rxd_m, rxd_s, rxd_d, rxd_fall, rxd_rise;

    // Tick counts must stay identical to the BAUDGEN divider table.
    function automatic logic [MEAS_W-1:0] rate_count(input logic [3:0] k);
        case (k)
            4'd0:    rate_count = MEAS_W'(28410);
            4'd1:    rate_count = MEAS_W'(10417);
            4'd2:    rate_count = MEAS_W'(5209);
            4'd3:    rate_count = MEAS_W'(2605);
            4'd4:    rate_count = MEAS_W'(1303);
            4'd5:    rate_count = MEAS_W'(652);
            4'd6:    rate_count = MEAS_W'(326);
            4'd7:    rate_count = MEAS_W'(218);
            4'd8:    rate_count = MEAS_W'(162);
            4'd9:    rate_count = MEAS_W'(82);
            4'd10:   rate_count = MEAS_W'(55);
            4'd11:   rate_count = MEAS_W'(28);
            4'd12:   rate_count = MEAS_W'(25);
            4'd13:   rate_count = MEAS_W'(13);
            default: rate_count = '0;
        endcase
    endfunction

    assign rxd_fall = rxd_d & ~rxd_s;
    assign rxd_rise = ~rxd_d & rxd_s;
    assign cfg_busy = (state != IDLE);
    assign est      = w_cnt >> 4;
    assign cnt_k    = rate_count(k_cnt);
    assign diff     = (est >= cnt_k) ? (est - cnt_k) : (cnt_k - est);

    always_comb begin
        state_n    = state;
        set_baud_n = set_baud;
        pend_n     = pend;
        arm_n      = arm_cnt;
        w_n        = w_cnt;
        tick_n     = tick_cnt;
        k_n        = k_cnt;
        best_n     = best;
        bd_n       = best_diff;
        done_n     = 1'b0;
        fail_n     = 1'b0;
        reject     = (state != IDLE) && (cfg_wr || auto_req);
        case (state)
            IDLE: begin
                if (cfg_wr) begin
                    if (cfg_baud <= 4'd13) begin
                        pend_n  = cfg_baud;
                        state_n = PEND;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (auto_req) begin
                    arm_n   = '0;
                    state_n = AUTO_ARM;
                end
            end
            PEND: begin
                if (!link_busy && baudtick) begin
                    set_baud_n = pend;
                    tick_n     = '0;
                    state_n    = SETTLE;
                end
            end
            SETTLE: begin
                if (baudtick) begin
                    if (tick_cnt == TW'(SETTLE_TICKS - 1)) state_n = IDLE;
                    else                                    tick_n  = tick_cnt + 1'b1;
                end
            end
            AUTO_ARM: begin
                if (rxd_fall) begin
                    w_n     = MEAS_W'(1);
                    state_n = AUTO_MEAS;
                end else if (arm_cnt == AW'(ARM_TIMEOUT - 1)) begin
                    fail_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    arm_n = arm_cnt + 1'b1;
                end
            end
            AUTO_MEAS: begin
                if (rxd_rise) begin
                    if (w_cnt < MEAS_W'(MIN_W)) begin
                        fail_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        k_n     = '0;
                        best_n  = '0;
                        bd_n    = '1;
                        state_n = AUTO_SRCH;
                    end
                end else if (!rxd_s) begin
                    if (w_cnt == W_MAX) begin
                        fail_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        w_n = w_cnt + 1'b1;
                    end
                end
            end
            AUTO_SRCH: begin
                // Strict compare keeps the lower code on ties.
                if (diff < best_diff) begin
                    best_n = k_cnt;
                    bd_n   = diff;
                end
                if (k_cnt == 4'd13) begin
                    set_baud_n = best_n;
                    done_n     = 1'b1;
                    tick_n     = '0;
                    state_n    = SETTLE;
                end else begin
                    k_n = k_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A rejection coinciding with an autobaud result is held one cycle so pulses never overlap.
        err_n      = (reject || err_pend) && !(done_n || fail_n);
        err_pend_n = (reject || err_pend) &&  (done_n || fail_n);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            set_baud  <= RESET_BAUD;
            pend      <= '0;
            arm_cnt   <= '0;
            w_cnt     <= '0;
            tick_cnt  <= '0;
            k_cnt     <= '0;
            best      <= '0;
            best_diff <= '0;
            err_pend  <= 1'b0;
            cfg_err   <= 1'b0;
            auto_done <= 1'b0;
            auto_fail <= 1'b0;
            rxd_m     <= 1'b1;
            rxd_s     <= 1'b1;
            rxd_d     <= 1'b1;
        end else begin
            state     <= state_n;
            set_baud  <= set_baud_n;
            pend      <= pend_n;
            arm_cnt   <= arm_n;
            w_cnt     <= w_n;
            tick_cnt  <= tick_n;
            k_cnt     <= k_n;
            best      <= best_n;
            best_diff <= bd_n;
            err_pend  <= err_pend_n;
            cfg_err   <= err_n;
            auto_done <= done_n;
            auto_fail <= fail_n;
            rxd_m     <= rxd;
            rxd_s     <= rxd_m;
            rxd_d     <= rxd_s;
        end
    end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_uart_baud_ctrl;

    localparam int ARM_TO = 2000;
    localparam int K_ERR = 0, K_DONE = 1, K_FAIL = 2, K_BAUD = 3;

    logic       clk = 1'b0, resetn = 1'b0;
    logic       cfg_wr = 1'b0, auto_req = 1'b0, link_busy = 1'b0, rxd = 1'b1;
    logic [3:0] cfg_baud = 4'd0;
    logic       tick_mode = 1'b0, tick_force = 1'b0, tick_rand = 1'b0;
    logic       baudtick;
    logic [3:0] set_baud;
    logic       cfg_busy, cfg_err, auto_done, auto_fail;

    assign baudtick = tick_mode ? tick_force : tick_rand;

    uart_baud_ctrl #(.ARM_TIMEOUT(ARM_TO)) dut (
        .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
        .auto_req(auto_req), .link_busy(link_busy), .rxd(rxd), .baudtick(baudtick),
        .set_baud(set_baud), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .auto_done(auto_done), .auto_fail(auto_fail)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int val;} exp_t;
    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   model_baud = 6;
    int   tbl[14] = '{28410, 10417, 5209, 2605, 1303, 652, 326, 218, 162, 82, 55, 28, 25, 13};
    logic [3:0] prev_baud = 4'd6;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Nearest-rate reference: est = width/16, first code with the smallest distance wins.
    task automatic ref_auto(input int w, output bit fail, output int code);
        int est, bd, d;
        fail = (w < 64);
        est  = w / 16;
        code = 0;
        bd   = (est > tbl[0]) ? est - tbl[0] : tbl[0] - est;
        for (int k = 1; k < 14; k++) begin
            d = (est > tbl[k]) ? est - tbl[k] : tbl[k] - est;
            if (d < bd) begin
                bd   = d;
                code = k;
            end
        end
    endtask

    // Monitor: every output event consumes one expected entry.
    always @(negedge clk) begin
        int   npulse, kind;
        exp_t e;
        if (!resetn) begin
            prev_baud = set_baud;
        end else begin
            npulse = int'(cfg_err) + int'(auto_done) + int'(auto_fail);
            if (npulse > 1) check("pulse_overlap", 32'(npulse), 32'd1);
            if (npulse != 0 || set_baud != prev_baud) begin
                kind = cfg_err ? K_ERR : auto_done ? K_DONE : auto_fail ? K_FAIL : K_BAUD;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(kind), 32'd99);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    if (kind == K_DONE || kind == K_BAUD)
                        check("event_baud", 32'(set_baud), 32'(e.val));
                end
            end
            prev_baud = set_baud;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        tick_rand = ($urandom_range(0, 3) == 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        check("idle_wait", 32'(ok), 32'd1);
        step();
    endtask

    task automatic do_cfg(input int code, input int busy);
        if (code > 13) push(K_ERR, 0);
        else if (code != model_baud) push(K_BAUD, code);
        if (code <= 13) model_baud = code;
        link_busy = (busy > 0);
        cfg_baud  = 4'(code);
        cfg_wr    = 1'b1;
        step();
        cfg_wr = 1'b0;
        repeat (busy) step();
        link_busy = 1'b0;
        wait_idle(2000);
        check("cfg_final_baud", 32'(set_baud), 32'(model_baud));
    endtask

    task automatic do_auto(input int n, input bit stray, input bit lb);
        bit f;
        int code;
        link_busy = lb;
        auto_req  = 1'b1;
        step();
        auto_req = 1'b0;
        repeat (3) step();
        rxd = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (stray && i == n / 2) begin
                cfg_wr   = 1'b1;
                cfg_baud = 4'($urandom_range(0, 13));
                push(K_ERR, 0);
            end
            step();
            cfg_wr = 1'b0;
        end
        rxd = 1'b1;
        ref_auto(n, f, code);
        if (f) push(K_FAIL, 0);
        else begin
            push(K_DONE, code);
            model_baud = code;
        end
        link_busy = 1'b0;
        wait_idle(2000);
        check("auto_final_baud", 32'(set_baud), 32'(model_baud));
    endtask

    initial begin
        // Reset with no stimulus
        repeat (3) step();
        resetn = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check("reset_baud", 32'(set_baud), 32'd6);
        check("reset_busy", 32'(cfg_busy), 32'd0);
        check("reset_pulses", 32'({cfg_err, auto_done, auto_fail}), 32'd0);
        step();

        // Rate change held off by link_busy, then applied on the first free tick
        tick_mode  = 1'b1;
        tick_force = 1'b0;
        push(K_BAUD, 11);
        model_baud = 11;
        link_busy  = 1'b1;
        cfg_baud   = 4'd11;
        cfg_wr     = 1'b1;
        step();
        cfg_wr = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick_force = (i % 16 == 0);
            step();
        end
        tick_force = 1'b0;
        @(negedge clk);
        check("pend_hold_baud", 32'(set_baud), 32'd6);
        check("pend_busy", 32'(cfg_busy), 32'd1);
        step();
        link_busy = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("pend_no_tick", 32'(set_baud), 32'd6);
        step();
        tick_force = 1'b1;
        @(negedge clk);
        check("tick_cycle_baud", 32'(set_baud), 32'd6);
        step();
        tick_force = 1'b0;
        @(negedge clk);
        check("after_tick_baud", 32'(set_baud), 32'd11);
        for (int t = 1; t <= 4; t++) begin
            repeat (2) step();
            tick_force = 1'b1;
            step();
            tick_force = 1'b0;
            @(negedge clk);
            check(t < 4 ? "settle_busy" : "settle_done", 32'(cfg_busy), t < 4 ? 32'd1 : 32'd0);
            if (t == 1) begin
                step();
                cfg_wr   = 1'b1;
                cfg_baud = 4'd3;
                push(K_ERR, 0);
                step();
                cfg_wr = 1'b0;
            end
        end
        step();
        @(negedge clk);
        check("settle_err_baud", 32'(set_baud), 32'd11);
        step();
        tick_mode = 1'b0;

        // Out-of-range codes
        do_cfg(14, 0);
        do_cfg(15, 3);

        // Autobaud: table points, glitches, minimum width and a tie
        do_auto(5232, 0, 0);
        do_auto(464, 1, 1);
        do_auto(40, 1, 0);
        do_auto(63, 0, 0);
        do_auto(64, 0, 0);
        do_auto(3040, 1, 0);
        do_auto(2640, 0, 1);

        // Arm timeout
        auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        repeat (ARM_TO - 50) step();
        @(negedge clk);
        check("arm_still_waiting", 32'(cfg_busy), 32'd1);
        push(K_FAIL, 0);
        wait_idle(200);
        check("timeout_baud", 32'(set_baud), 32'(model_baud));

        // Reset mid-measurement, then an immediate write
        auto_req = 1'b1;
        step();
        auto_req = 1'b0;
        repeat (3) step();
        rxd = 1'b0;
        repeat (100) step();
        resetn = 1'b0;
        rxd    = 1'b1;
        @(negedge clk);
        check("meas_rst_baud", 32'(set_baud), 32'd6);
        check("meas_rst_busy", 32'(cfg_busy), 32'd0);
        step();
        resetn     = 1'b1;
        model_baud = 6;
        @(negedge clk);
        check("meas_post_busy", 32'(cfg_busy), 32'd0);
        step();
        do_cfg(2, 0);

        // Reset mid-settle
        tick_mode  = 1'b1;
        tick_force = 1'b0;
        push(K_BAUD, 9);
        cfg_baud = 4'd9;
        cfg_wr   = 1'b1;
        step();
        cfg_wr = 1'b0;
        step();
        tick_force = 1'b1;
        step();
        tick_force = 1'b0;
        step();
        @(negedge clk);
        check("settle_pre_baud", 32'(set_baud), 32'd9);
        check("settle_pre_busy", 32'(cfg_busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("settle_rst_baud", 32'(set_baud), 32'd6);
        check("settle_rst_busy", 32'(cfg_busy), 32'd0);
        step();
        resetn     = 1'b1;
        model_baud = 6;
        tick_mode  = 1'b0;
        step();
        do_cfg(4, 2);

        // Randomized mix
        for (int it = 0; it < 20; it++) begin
            int op, w;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_cfg($urandom_range(0, 15), $urandom_range(0, 40));
            end else begin
                w = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 63) : $urandom_range(64, 2000);
                do_auto(w, (w >= 40) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
            end
        end

        repeat (20) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
